hazard_stall_ctrl: RTL

Central pipeline sequencer for the 5-stage CPU with the one-way dcache. It detects load-use hazards and drives the select of the ID/EX control-bubble mux. It freezes the whole pipeline while the dcache reports a miss, and holds a branch-flush request raised during a freeze until the freeze releases. It also keeps a saturating stall-cycle counter and a sticky miss-timeout flag.

---
 rtl/hazard_stall_ctrl_pkg.sv | 19 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall sequencer.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_MISS_WAIT = 1'b1
  } state_e;

  localparam int unsigned REG_W_DEF   = 5;
  localparam int unsigned TIMEOUT_DEF = 1023;
  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  localparam int unsigned ZERO_REG    = 0;

  // Smallest counter width whose all-ones value reaches max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module hazard_stall_ctrl_sat_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use bubbles, dcache-miss freeze, deferred branch flush,
// stall-cycle statistics and a sticky miss-timeout flag.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             dcache_stall_i,
  input  logic             branch_flush_i,
  output logic             bubble_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned MissW = cnt_width(TIMEOUT);

  state_e           state_q, state_d;
  logic             pend_flush_q, pend_flush_d;
  logic             timeout_q, timeout_d;
  logic             miss_inc, miss_clr;
  logic [MissW-1:0] miss_cnt;
  logic             lu;

  logic bubble, pc_write, ifid_write, ifid_flush, freeze;

  assign lu = idex_memread_i && (idex_rt_i != REG_W'(ZERO_REG)) &&
              ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    timeout_d    = timeout_q;
    bubble       = 1'b0;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    freeze       = 1'b0;
    miss_inc     = 1'b0;
    miss_clr     = 1'b0;
    if (!rst_i) begin
      bubble = 1'b1;
    end else if (dcache_stall_i) begin
      // Freeze outranks any load-use bubble; a flush seen now is replayed on release.
      freeze  = 1'b1;
      state_d = ST_MISS_WAIT;
      if (branch_flush_i) begin
        pend_flush_d = 1'b1;
      end
      if (state_q == ST_MISS_WAIT) begin
        miss_inc = 1'b1;
        // Sets at the edge where the miss count reaches TIMEOUT.
        if (miss_cnt >= MissW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
        end
      end
    end else begin
      bubble       = lu;
      pc_write     = ~lu;
      ifid_write   = ~lu;
      ifid_flush   = branch_flush_i | pend_flush_q;
      pend_flush_d = 1'b0;
      state_d      = ST_RUN;
      miss_clr     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_RUN;
      pend_flush_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      timeout_q    <= timeout_d;
    end
  end

  hazard_stall_ctrl_sat_counter #(
    .Width (MissW)
  ) u_miss_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .inc_i  (miss_inc),
    .clr_i  (miss_clr),
    .cnt_o  (miss_cnt)
  );

  hazard_stall_ctrl_sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .inc_i  (~pc_write),
    .clr_i  (1'b0),
    .cnt_o  (stall_cnt_o)
  );

  assign bubble_o     = bubble;
  assign pc_write_o   = pc_write;
  assign ifid_write_o = ifid_write;
  assign ifid_flush_o = ifid_flush;
  assign freeze_o     = freeze;
  assign timeout_o    = timeout_q;

endmodule
